sale_terminal_ctrl: RTL and testbench

//  Parametrised mode/entry controller for the sale terminal; successor to the fixed 4-digit/4-key FSM.

---
 rtl/sale_terminal_pkg.sv | 30 +++
 rtl/key_onehot_enc.sv | 21 ++
 rtl/sale_terminal_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_sale_terminal_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sale_terminal_pkg.sv
// Shared state encoding, direction codes and command bit index for the sale terminal controller.
package sale_terminal_pkg;

  typedef enum logic [3:0] {
    ST_START   = 4'd0,
    ST_IDLE    = 4'd1,
    ST_BARCODE = 4'd2,
    ST_INTER   = 4'd3,
    ST_QTY     = 4'd4,
    ST_ADD     = 4'd5,
    ST_EDIT    = 4'd6,
    ST_END     = 4'd7,
    ST_ERROR   = 4'd8
  } state_e;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int CMD_SELECT = 0;

  // ERROR has no display code of its own; it shares 7 with END and is told apart by err.
  function automatic logic [2:0] state_code(input state_e s);
    logic [3:0] v;
    v = s;
    return (s == ST_ERROR) ? 3'd7 : v[2:0];
  endfunction

endpackage

// File: rtl/key_onehot_enc.sv
// One-hot key decoder: flags a single pressed key and returns its index; zero or several keys are invalid.
module key_onehot_enc #(
  parameter int KEY_N = 4,
  parameter int IDX_W = (KEY_N > 1) ? $clog2(KEY_N) : 1
) (
  input  logic [KEY_N-1:0] key_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  assign valid_o = (key_i != '0) && ((key_i & (key_i - 1'b1)) == '0);

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < KEY_N; i++) begin
      if (key_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/sale_terminal_ctrl.sv
// Sale terminal mode/entry controller with registered outputs and an ERROR hold state.
// Optional inactivity timeout is enabled by defining SALE_CTRL_TIMEOUT_EN.
module sale_terminal_ctrl
  import sale_terminal_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int KEY_N    = 4,
  parameter int DIGIT_W  = 4,
  parameter int QTY_W    = 3,
  parameter int ERR_HOLD = 8,
  parameter int TMO_CYC  = 1024
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic [3:0]         cmd_pulse,
  input  logic [KEY_N-1:0]   key_pulse,
  input  logic [1:0]         sw_mode,
  input  logic               digit_done,
  input  logic               product_valid,
  input  logic               basket_full,
  input  logic               add_ack,
  output logic               digit_en,
  output logic [DIGIT_W-1:0] digit_val,
  output logic               bc_clr_n,
  output logic               dir_valid,
  output logic [1:0]         dir,
  output logic               add_req,
  output logic [QTY_W-1:0]   add_qty,
  output logic               del_req,
  output logic               err,
  output logic [2:0]         state_o
);

  localparam int IDX_W = (KEY_N > 1) ? $clog2(KEY_N) : 1;
  localparam int ERR_W = $clog2(ERR_HOLD + 1);

  state_e             state_q, state_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               qty_first_q;
  logic               digit_en_q, digit_en_d, bc_clr_n_q, bc_clr_n_d;
  logic               dir_valid_q, dir_valid_d, add_req_q, add_req_d, del_req_q, del_req_d;
  logic [DIGIT_W-1:0] digit_val_q, digit_val_d;
  logic [1:0]         dir_q, dir_d;
  logic [QTY_W-1:0]   add_qty_q, add_qty_d;

  logic             key_ok, dir_ok, sel, act, tmo_hit, unused_cmd;
  logic [IDX_W-1:0] key_idx;

  key_onehot_enc #(.KEY_N(KEY_N), .IDX_W(IDX_W)) u_key_enc (
    .key_i  (key_pulse),
    .valid_o(key_ok),
    .idx_o  (key_idx)
  );

  assign sel        = cmd_pulse[CMD_SELECT];
  assign act        = sel | key_ok;
  assign dir_ok     = key_ok && (32'(key_idx) < 32'd4);
  assign unused_cmd = ^cmd_pulse;

`ifdef SALE_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam int unused_digits = DIGITS;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_zone;

  // The counter restarts on every state change so each timed state gets a full window.
  assign tmo_zone = state_q inside {ST_BARCODE, ST_QTY, ST_INTER};
  assign tmo_hit  = tmo_zone && !act && (tmo_q == TMO_W'(TMO_CYC - 1));

  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (!tmo_zone || act || tmo_hit || (state_d != state_q)) tmo_d = '0;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  localparam int unused_params = DIGITS + TMO_CYC;
  assign tmo_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_START;
      err_cnt_q   <= '0;
      qty_first_q <= 1'b0;
      digit_en_q  <= 1'b0;
      digit_val_q <= '0;
      bc_clr_n_q  <= 1'b1;
      dir_valid_q <= 1'b0;
      dir_q       <= '0;
      add_req_q   <= 1'b0;
      add_qty_q   <= '0;
      del_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_cnt_q   <= err_cnt_d;
      qty_first_q <= (state_d == ST_QTY) && (state_q != ST_QTY);
      digit_en_q  <= digit_en_d;
      digit_val_q <= digit_val_d;
      bc_clr_n_q  <= bc_clr_n_d;
      dir_valid_q <= dir_valid_d;
      dir_q       <= dir_d;
      add_req_q   <= add_req_d;
      add_qty_q   <= add_qty_d;
      del_req_q   <= del_req_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    err_cnt_d = '0;
    case (state_q)
      ST_START: state_d = ST_IDLE;
      ST_IDLE: begin
        if (sel)             state_d = ST_END;
        else if (sw_mode[1]) state_d = ST_EDIT;
        else if (sw_mode[0]) state_d = ST_INTER;
        else                 state_d = ST_BARCODE;
      end
      ST_BARCODE: begin
        if (sw_mode != 2'b00)       state_d = ST_IDLE;
        else if (sel && digit_done) state_d = product_valid ? ST_QTY : ST_ERROR;
        else if (tmo_hit)           state_d = ST_IDLE;
      end
      ST_INTER: begin
        if (!sw_mode[0])  state_d = ST_IDLE;
        else if (sel)     state_d = ST_QTY;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_QTY: begin
        if (qty_first_q && basket_full) state_d = ST_ERROR;
        else if (key_ok && !sel)        state_d = ST_ADD;
        else if (tmo_hit)               state_d = ST_IDLE;
      end
      ST_ADD:  if (add_ack) state_d = ST_IDLE;
      ST_EDIT: if (!sw_mode[1]) state_d = ST_IDLE;
      ST_END:  state_d = ST_START;
      ST_ERROR: begin
        if (err_cnt_q == ERR_W'(ERR_HOLD - 1)) state_d = ST_IDLE;
        else                                   err_cnt_d = err_cnt_q + 1'b1;
      end
      default: state_d = ST_START;
    endcase
  end

  // Next values of the output registers; a Select in the same cycle masks any key.
  always_comb begin
    digit_en_d  = 1'b0;
    dir_valid_d = 1'b0;
    del_req_d   = 1'b0;
    bc_clr_n_d  = 1'b1;
    digit_val_d = digit_val_q;
    dir_d       = dir_q;
    add_req_d   = add_req_q;
    add_qty_d   = add_qty_q;
    case (state_q)
      ST_START: bc_clr_n_d = 1'b0;
      ST_BARCODE: begin
        if (sw_mode == 2'b00) begin
          if (sel) begin
            if (digit_done && !product_valid) bc_clr_n_d = 1'b0;
          end else if (!digit_done && key_ok) begin
            digit_en_d  = 1'b1;
            digit_val_d = DIGIT_W'(key_idx) + DIGIT_W'(1);
          end else if (tmo_hit) begin
            bc_clr_n_d = 1'b0;
          end
        end
      end
      ST_INTER: begin
        if (sw_mode[0] && !sel) begin
          if (dir_ok) begin
            dir_valid_d = 1'b1;
            dir_d       = DIR_RIGHT - 2'(key_idx);
          end else if (tmo_hit) begin
            bc_clr_n_d = 1'b0;
          end
        end
      end
      ST_QTY: begin
        if (!(qty_first_q && basket_full)) begin
          if (key_ok && !sel) begin
            add_req_d = 1'b1;
            add_qty_d = QTY_W'(key_idx) + QTY_W'(1);
          end else if (tmo_hit) begin
            bc_clr_n_d = 1'b0;
          end
        end
      end
      ST_ADD: begin
        if (add_ack) begin
          add_req_d  = 1'b0;
          bc_clr_n_d = 1'b0;
        end
      end
      ST_EDIT: begin
        if (sw_mode[1]) begin
          if (sel) begin
            del_req_d = 1'b1;
          end else if (dir_ok) begin
            dir_valid_d = 1'b1;
            dir_d       = DIR_RIGHT - 2'(key_idx);
          end
        end
      end
      default: ;
    endcase
  end

  assign digit_en  = digit_en_q;
  assign digit_val = digit_val_q;
  assign bc_clr_n  = bc_clr_n_q;
  assign dir_valid = dir_valid_q;
  assign dir       = dir_q;
  assign add_req   = add_req_q;
  assign add_qty   = add_qty_q;
  assign del_req   = del_req_q;
  assign err       = (state_q == ST_ERROR);
  assign state_o   = state_code(state_q);

endmodule

// File: tb/tb_sale_terminal_ctrl.sv
// Directed self-checking bench for sale_terminal_ctrl; the timeout scenario runs only with SALE_CTRL_TIMEOUT_EN.
module tb_sale_terminal_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cmd_pulse, key_pulse;
  logic [1:0] sw_mode;
  logic       digit_done, product_valid, basket_full, add_ack;
  logic       digit_en, bc_clr_n, dir_valid, add_req, del_req, err;
  logic [3:0] digit_val;
  logic [1:0] dir;
  logic [2:0] add_qty, state_o;

  int checks = 0;
  int errors = 0;

  sale_terminal_ctrl #(
    .DIGITS(4), .KEY_N(4), .DIGIT_W(4), .QTY_W(3), .ERR_HOLD(8), .TMO_CYC(16)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .cmd_pulse(cmd_pulse), .key_pulse(key_pulse),
    .sw_mode(sw_mode), .digit_done(digit_done), .product_valid(product_valid),
    .basket_full(basket_full), .add_ack(add_ack), .digit_en(digit_en), .digit_val(digit_val),
    .bc_clr_n(bc_clr_n), .dir_valid(dir_valid), .dir(dir), .add_req(add_req),
    .add_qty(add_qty), .del_req(del_req), .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_pulse = '0; key_pulse = '0; sw_mode = '0;
    digit_done = 0; product_valid = 0; basket_full = 0; add_ack = 0;
    repeat (3) tick();
    checks++;
    if ({state_o, bc_clr_n, add_req, add_qty, digit_en, digit_val, dir_valid, dir, del_req, err}
        !== {3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values state=%0d clr_n=%b req=%b qty=%0d den=%b dval=%0d dv=%b dir=%0d del=%b err=%b",
               state_o, bc_clr_n, add_req, add_qty, digit_en, digit_val, dir_valid, dir, del_req, err);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (state_o !== 3'd1 || bc_clr_n !== 1'b0) begin
      errors++; $display("FAIL start_clear state=%0d clr_n=%b want 1/0", state_o, bc_clr_n);
    end
    tick();
    checks++;
    if (state_o !== 3'd2 || bc_clr_n !== 1'b1) begin
      errors++; $display("FAIL enter_barcode state=%0d clr_n=%b want 2/1", state_o, bc_clr_n);
    end
  endtask

  task automatic test_barcode();
    for (int i = 0; i < 4; i++) begin
      key_pulse = 4'b0001 << i;
      tick();
      key_pulse = '0;
      checks++;
      if (digit_en !== 1'b1 || digit_val !== 4'(i + 1)) begin
        errors++; $display("FAIL digit_%0d en=%b val=%0d want 1/%0d", i, digit_en, digit_val, i + 1);
      end
    end
    digit_done = 1'b1;
    key_pulse = 4'b0001;
    tick();
    key_pulse = '0;
    checks++;
    if (digit_en !== 1'b0 || state_o !== 3'd2) begin
      errors++; $display("FAIL key_after_done en=%b state=%0d want 0/2", digit_en, state_o);
    end
  endtask

  task automatic test_error();
    int n;
    product_valid = 1'b0;
    cmd_pulse = 4'b0001;
    tick();
    cmd_pulse = '0;
    checks++;
    if (err !== 1'b1 || bc_clr_n !== 1'b0 || state_o !== 3'd7) begin
      errors++; $display("FAIL bad_barcode err=%b clr_n=%b state=%0d want 1/0/7", err, bc_clr_n, state_o);
    end
    tick();
    checks++;
    if (bc_clr_n !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL clear_one_cycle clr_n=%b err=%b want 1/1", bc_clr_n, err);
    end
    n = 1;
    while (err === 1'b1 && n < 50) begin n++; tick(); end
    checks++;
    if (n !== 8 || state_o !== 3'd1) begin
      errors++; $display("FAIL err_hold cycles=%0d state=%0d want 8/1", n, state_o);
    end
  endtask

  task automatic test_add();
    product_valid = 1'b1;
    tick();
    cmd_pulse = 4'b0001;
    tick();
    cmd_pulse = '0;
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL select_to_qty state=%0d want 4", state_o); end
    key_pulse = 4'b0100;
    tick();
    key_pulse = '0;
    sw_mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (add_req !== 1'b1 || add_qty !== 3'd3 || state_o !== 3'd5) begin
        errors++; $display("FAIL add_hold_%0d req=%b qty=%0d state=%0d want 1/3/5", i, add_req, add_qty, state_o);
      end
      if (i < 4) tick();
    end
    sw_mode = 2'b00;
    add_ack = 1'b1;
    tick();
    add_ack = 1'b0;
    checks++;
    if (add_req !== 1'b0 || bc_clr_n !== 1'b0 || state_o !== 3'd1) begin
      errors++; $display("FAIL add_ack req=%b clr_n=%b state=%0d want 0/0/1", add_req, bc_clr_n, state_o);
    end
    digit_done = 1'b0;
    product_valid = 1'b0;
  endtask

  task automatic test_inter();
    sw_mode = 2'b01;
    tick();
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL enter_inter state=%0d want 3", state_o); end
    key_pulse = 4'b1000;
    tick();
    key_pulse = '0;
    checks++;
    if (dir_valid !== 1'b1 || dir !== 2'b00) begin
      errors++; $display("FAIL dir_left dv=%b dir=%b want 1/00", dir_valid, dir);
    end
    tick();
    checks++;
    if (dir_valid !== 1'b0) begin errors++; $display("FAIL dir_pulse_width dv=%b want 0", dir_valid); end
    key_pulse = 4'b0001;
    tick();
    checks++;
    if (dir_valid !== 1'b1 || dir !== 2'b11) begin
      errors++; $display("FAIL dir_right dv=%b dir=%b want 1/11", dir_valid, dir);
    end
    key_pulse = 4'b0011;
    tick();
    checks++;
    if (dir_valid !== 1'b0) begin errors++; $display("FAIL multi_hot dv=%b want 0", dir_valid); end
    cmd_pulse = 4'b0001;
    key_pulse = 4'b0010;
    tick();
    cmd_pulse = '0;
    key_pulse = '0;
    checks++;
    if (dir_valid !== 1'b0 || state_o !== 3'd4) begin
      errors++; $display("FAIL select_priority dv=%b state=%0d want 0/4", dir_valid, state_o);
    end
  endtask

  task automatic test_back_to_back_ack();
    key_pulse = 4'b0001;
    add_ack = 1'b1;
    tick();
    key_pulse = '0;
    checks++;
    if (add_req !== 1'b1 || add_qty !== 3'd1) begin
      errors++; $display("FAIL qty_one req=%b qty=%0d want 1/1", add_req, add_qty);
    end
    tick();
    add_ack = 1'b0;
    checks++;
    if (add_req !== 1'b0 || state_o !== 3'd1) begin
      errors++; $display("FAIL early_ack req=%b state=%0d want 0/1", add_req, state_o);
    end
  endtask

  task automatic test_basket_full();
    int n;
    basket_full = 1'b1;
    tick();
    cmd_pulse = 4'b0001;
    tick();
    cmd_pulse = '0;
    key_pulse = 4'b0001;
    tick();
    key_pulse = '0;
    checks++;
    if (err !== 1'b1 || state_o !== 3'd7 || add_req !== 1'b0) begin
      errors++; $display("FAIL basket_full err=%b state=%0d req=%b want 1/7/0", err, state_o, add_req);
    end
    basket_full = 1'b0;
    n = 0;
    while (err === 1'b1 && n < 50) begin n++; tick(); end
    checks++;
    if (n !== 8 || state_o !== 3'd1) begin
      errors++; $display("FAIL full_recover cycles=%0d state=%0d want 8/1", n, state_o);
    end
  endtask

  task automatic test_edit_end();
    sw_mode = 2'b10;
    tick();
    checks++;
    if (state_o !== 3'd6) begin errors++; $display("FAIL enter_edit state=%0d want 6", state_o); end
    cmd_pulse = 4'b0001;
    tick();
    cmd_pulse = '0;
    checks++;
    if (del_req !== 1'b1) begin errors++; $display("FAIL del_req got=%b want 1", del_req); end
    key_pulse = 4'b0100;
    tick();
    key_pulse = '0;
    checks++;
    if (del_req !== 1'b0 || dir_valid !== 1'b1 || dir !== 2'b01) begin
      errors++; $display("FAIL edit_dir del=%b dv=%b dir=%b want 0/1/01", del_req, dir_valid, dir);
    end
    sw_mode = 2'b00;
    tick();
    cmd_pulse = 4'b0001;
    tick();
    cmd_pulse = '0;
    checks++;
    if (state_o !== 3'd7 || err !== 1'b0) begin
      errors++; $display("FAIL end_state state=%0d err=%b want 7/0", state_o, err);
    end
    tick();
    tick();
    checks++;
    if (state_o !== 3'd1 || bc_clr_n !== 1'b0) begin
      errors++; $display("FAIL end_restart state=%0d clr_n=%b want 1/0", state_o, bc_clr_n);
    end
  endtask

  task automatic test_reset_mid_add();
    digit_done = 1'b1;
    product_valid = 1'b1;
    tick();
    cmd_pulse = 4'b0001;
    tick();
    cmd_pulse = '0;
    key_pulse = 4'b1000;
    tick();
    key_pulse = '0;
    checks++;
    if (add_req !== 1'b1 || add_qty !== 3'd4) begin
      errors++; $display("FAIL qty_four req=%b qty=%0d want 1/4", add_req, add_qty);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (add_req !== 1'b0 || add_qty !== 3'd0 || state_o !== 3'd0) begin
      errors++; $display("FAIL async_reset req=%b qty=%0d state=%0d want 0/0/0", add_req, add_qty, state_o);
    end
    digit_done = 1'b0;
    product_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

`ifdef SALE_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    n = 0;
    while (bc_clr_n === 1'b1 && n < 40) begin n++; tick(); end
    checks++;
    if (n !== 16 || state_o !== 3'd1) begin
      errors++; $display("FAIL timeout cycles=%0d state=%0d want 16/1", n, state_o);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SALE_CTRL_TIMEOUT_EN
    test_timeout();
    test_reset();
`endif
    test_barcode();
    test_error();
    test_add();
    test_inter();
    test_back_to_back_ack();
    test_basket_full();
    test_edit_end();
    test_reset_mid_add();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
